// File: rtl/bcd_serial_adder.sv
// Serial packed-BCD adder/subtractor: one decimal digit per clock, LS digit first.
// Shares one 4-bit binary adder with +6 decimal correction and uses a start/busy/done handshake.
module bcd_serial_adder #(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Start,
    input  logic                 Sub,
    input  logic [4*NDIGITS-1:0] A,
    input  logic [4*NDIGITS-1:0] B,
    input  logic                 Cin,
    output logic [4*NDIGITS-1:0] Sum,
    output logic                 Cout,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err
);

    localparam int unsigned W  = 4 * NDIGITS;
    localparam int unsigned KW = $clog2(NDIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res;
    logic [KW-1:0]   k;
    logic            carry;
    logic            sub_r;
    logic            err_work;

    logic [3:0]      b_eff_c;
    logic [4:0]      s_c;
    logic [3:0]      digit_c;
    logic            carry_c;
    logic            err_c;

    // Single digit slice: binary add, then decimal correction when the sum exceeds 9.
    always_comb begin
        b_eff_c = sub_r ? 4'(4'd9 - b_sh[3:0]) : b_sh[3:0];
        s_c     = 5'(a_sh[3:0]) + 5'(b_eff_c) + 5'(carry);
        digit_c = s_c[3:0];
        carry_c = 1'b0;
        if (s_c > 5'd9) begin
            digit_c = 4'(s_c + 5'd6);
            carry_c = 1'b1;
        end
        err_c = (a_sh[3:0] > 4'd9) | (b_sh[3:0] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            k        <= '0;
            carry    <= 1'b0;
            sub_r    <= 1'b0;
            err_work <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state    <= RUN;
                        Busy     <= 1'b1;
                        a_sh     <= A;
                        b_sh     <= B;
                        carry    <= Cin;
                        sub_r    <= Sub;
                        res      <= '0;
                        k        <= '0;
                        err_work <= 1'b0;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (k == KW'(NDIGITS)) begin
                        // All digits shifted in; publish the result.
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        Sum   <= res;
                        Cout  <= carry;
                        Err   <= err_work;
                    end else begin
                        res      <= (res >> 4) | (W'(digit_c) << (W - 4));
                        a_sh     <= a_sh >> 4;
                        b_sh     <= b_sh >> 4;
                        carry    <= carry_c;
                        err_work <= err_work | err_c;
                        k        <= k + KW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
